// File: rtl/tag_ram_ctrl_if.sv
// tag_ram_ctrl_if
//   Request/response bundle between the cache pipeline and tag_ram_ctrl.
//   master : cache pipeline side (drives requests, receives responses)
//   slave  : controller side
// Signals:
//   req_valid/req_ready  lookup handshake
//   req_index            set index (AWIDTH)
//   req_tag              tag to compare (TWIDTH)
//   req_alloc            write {valid,req_tag} on a miss
//   rsp_valid            one-cycle response strobe
//   rsp_hit              stored entry valid and tag equal
//   rsp_index            index of the responded request
//   rsp_tag              tag read from the RAM before any allocation
interface tag_ram_ctrl_if #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 13
);
  logic              req_valid;
  logic              req_ready;
  logic [AWIDTH-1:0] req_index;
  logic [TWIDTH-1:0] req_tag;
  logic              req_alloc;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [AWIDTH-1:0] rsp_index;
  logic [TWIDTH-1:0] rsp_tag;

  modport master (
    output req_valid, req_index, req_tag, req_alloc,
    input  req_ready, rsp_valid, rsp_hit, rsp_index, rsp_tag
  );

  modport slave (
    input  req_valid, req_index, req_tag, req_alloc,
    output req_ready, rsp_valid, rsp_hit, rsp_index, rsp_tag
  );
endinterface

// File: rtl/tag_ram_ctrl.sv
// tag_ram_ctrl
//   Controller for a single-port, synchronous-read tag RAM. After reset it
//   clears every entry, then serves lookups: one request per two cycles,
//   response two cycles after accept, optional allocate on miss.
//   Entry layout: bit TWIDTH = valid, bits [TWIDTH-1:0] = tag.
// Ports:
//   clock      sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   bus        tag_ram_ctrl_if.slave request/response bundle
//   init_done  high once the clear sequence has finished
//   ram_addr   RAM address (combinational)
//   ram_din    RAM write data (combinational)
//   ram_we     RAM write enable (combinational)
//   ram_dout   RAM read data, valid the cycle after the address is latched
//   flush_req  only with TAG_RAM_CTRL_FLUSH_EN: re-clear the RAM from IDLE
// Build option:
//   TAG_RAM_CTRL_FLUSH_EN  adds flush_req; without it INIT is reached only
//                          through reset.
//
// state     | meaning
// ST_INIT   | writing 0 to every entry, clr_cnt walks 0..DEPTH-1
// ST_IDLE   | ready for a request, RAM address follows req_index
// ST_LOOKUP | RAM data valid, compare and optionally allocate
module tag_ram_ctrl #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 13
) (
  input  logic                clock,
  input  logic                reset_n,
  tag_ram_ctrl_if.slave       bus,
`ifdef TAG_RAM_CTRL_FLUSH_EN
  input  logic                flush_req,
`endif
  output logic                init_done,
  output logic [AWIDTH-1:0]   ram_addr,
  output logic [TWIDTH:0]     ram_din,
  output logic                ram_we,
  input  logic [TWIDTH:0]     ram_dout
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LOOKUP = 2'd2
  } state_t;

  state_t            state;
  logic [AWIDTH-1:0] clr_cnt;
  logic [AWIDTH-1:0] held_index;
  logic [TWIDTH-1:0] held_tag;
  logic              held_alloc;
  logic              hit;
  logic              accept;
  logic              flush_take;

  assign hit    = ram_dout[TWIDTH] & (ram_dout[TWIDTH-1:0] == held_tag);
  assign accept = (state == ST_IDLE) & bus.req_valid;

`ifdef TAG_RAM_CTRL_FLUSH_EN
  // A request accepted in the same cycle takes priority over the flush.
  assign flush_take = (state == ST_IDLE) & flush_req & ~bus.req_valid;
`else
  assign flush_take = 1'b0;
`endif

  assign bus.req_ready = (state == ST_IDLE);

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = held_index;
    ram_din  = '0;
    case (state)
      ST_INIT: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt;
      end
      ST_IDLE: begin
        // RAM latches the read address on the accept edge.
        ram_addr = bus.req_index;
      end
      ST_LOOKUP: begin
        ram_we  = ~hit & held_alloc;
        ram_din = {1'b1, held_tag};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_INIT;
      clr_cnt       <= '0;
      init_done     <= 1'b0;
      held_index    <= '0;
      held_tag      <= '0;
      held_alloc    <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_hit   <= 1'b0;
      bus.rsp_index <= '0;
      bus.rsp_tag   <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          // Counter wraps to 0 after the last index, ready for a later flush.
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_IDX) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            held_index <= bus.req_index;
            held_tag   <= bus.req_tag;
            held_alloc <= bus.req_alloc;
            state      <= ST_LOOKUP;
          end else if (flush_take) begin
            clr_cnt   <= '0;
            init_done <= 1'b0;
            state     <= ST_INIT;
          end
        end
        ST_LOOKUP: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_hit   <= hit;
          bus.rsp_index <= held_index;
          bus.rsp_tag   <= ram_dout[TWIDTH-1:0];
          state         <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
